tdm_demux_1to2: RTL and testbench
=================================

Name: tdm_demux_1to2

Overview:
- Receive end of the 2:1 time-division link: the transmit side selects between two channel inputs onto a single serial line.
- This block deserialises that line back into two parallel channel words, framed by a SYNC strobe on the first bit.
- Updates both outputs together once per complete frame.
- Sits directly after the serial link input, before channel consumers.

Parameters:
WIDTH, 4, bits per channel word; legal range 2..16
CNT_W, 8, width of good-frame counter FRAME_CNT

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
EN  input  1  bit strobe; SIN/SYNC sampled only on cycles with EN=1
SIN  input  1  serial data, MSB first, channel 1 word then channel 2 word
SYNC  input  1  marks the first bit (channel 1 MSB) of a frame; qualified by EN
OUT1  output  WIDTH  last complete channel 1 word
OUT2  output  WIDTH  last complete channel 2 word
VALID  output  1  one-cycle pulse: OUT1/OUT2 just updated
SELECT  output  1  channel currently being received: 0 = channel 1, 1 = channel 2
FRAME_ERR  output  1  one-cycle pulse: SYNC seen mid-frame
FRAME_CNT  output  CNT_W  count of good frames, wraps

Behaviour:
- Reset (async, RST=1): state HUNT, shift register 0, bit counter 0, hold register 0. OUT1, OUT2, VALID, SELECT, FRAME_ERR and FRAME_CNT all 0. Reset takes effect immediately, even mid-frame; the partial frame is discarded.
- FSM states: HUNT, CH1, CH2. Bit counter is $clog2(WIDTH) bits.
- Cycles with EN=0: no state, counter or data change; SYNC and SIN ignored. VALID and FRAME_ERR are 0.
- HUNT:
  - EN=1 and SYNC=1: shift SIN in as the MSB, counter=1, go to CH1.
  - EN=1 and SYNC=0: bit discarded, stay in HUNT.
- CH1 (SELECT=0):
  - EN=1 and SYNC=0: shift SIN in.
  - On the WIDTH-th bit: move the assembled word to the hold register, counter=0, go to CH2.
- CH2 (SELECT=1):
  - EN=1 and SYNC=0: shift SIN in.
  - On the WIDTH-th bit, at the same edge: OUT1 <= hold register, OUT2 <= assembled word, VALID=1, FRAME_CNT += 1 (mod 2^CNT_W), go to HUNT.
- Latency: VALID, OUT1 and OUT2 are registered and visible the cycle after the EN cycle carrying the last frame bit.
- Back-to-back frames: a SYNC bit on the EN cycle immediately after the last bit is accepted by HUNT, so no gap bit is required.
- SYNC mid-frame (EN=1, SYNC=1 in CH1 or CH2):
  - FRAME_ERR=1 for one cycle; partial frame discarded.
  - The SYNC bit is taken as the MSB of a new frame: counter=1, state CH1.
  - OUT1, OUT2 and FRAME_CNT unchanged; VALID stays 0.
- Between valid frames OUT1/OUT2 hold their values; they never show a partially assembled word.
- SELECT is registered from the state: 1 only in CH2.
- VALID and FRAME_ERR are never asserted in the same cycle.

Test Plan:
- WIDTH=4, reset then EN=1 continuously, SYNC on bit 0, SIN=1010_0110 -> SELECT=0 for bits 0-3 and 1 for bits 4-7; cycle after bit 7: OUT1=4'hA, OUT2=4'h6, VALID=1 for exactly one cycle, FRAME_CNT=1.
- Same frame with EN=0 inserted for 3 cycles after bit 2 and 2 cycles after bit 5 -> same OUT1=4'hA, OUT2=4'h6, VALID once; no change during gaps.
- Frame 1111_0000 followed immediately by SYNC frame 0011_1100 -> VALID twice, 8 EN-cycles apart; final OUT1=4'h3, OUT2=4'hC, FRAME_CNT=2.
- SYNC asserted again at bit 5 of a frame, then a full 0101_1001 frame starting there -> FRAME_ERR pulse at bit 5; OUTs unchanged until the new frame completes; then OUT1=4'h5, OUT2=4'h9, FRAME_CNT increments once.
- RST pulsed asynchronously (between clock edges) during bit 3 of CH2 -> all outputs 0 immediately; subsequent bits without SYNC ignored (no VALID); next SYNC frame decodes correctly.
- CNT_W=2, five good frames -> FRAME_CNT sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/tdm_demux_1to2.sv
// Receive side of a 2:1 TDM serial link: deserialises SYNC-framed channel 1/2 words
// (MSB first) and publishes both words together once per complete frame.
module tdm_demux_1to2 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    input  logic             sync,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             valid,
    output logic             select,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CH1  = 2'd1,
        CH2  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [WIDTH-1:0] hold_r, hold_s;
    logic [WIDTH-1:0] out1_r, out1_s;
    logic [WIDTH-1:0] out2_r, out2_s;
    logic             valid_r, valid_s;
    logic             select_r, select_s;
    logic             ferr_r, ferr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] word_s;

    // Next-state, datapath and output pulse decode.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        hold_s    = hold_r;
        out1_s    = out1_r;
        out2_s    = out2_r;
        valid_s   = 1'b0;
        ferr_s    = 1'b0;
        cnt_s     = cnt_r;
        word_s    = {shift_r[WIDTH-2:0], sin};

        if (en) begin
            if (sync) begin
                // A SYNC always opens a new frame; mid-frame it also drops the partial one.
                ferr_s    = (state_r != HUNT);
                shift_s   = word_s;
                bit_cnt_s = BW'(1);
                state_s   = CH1;
            end else begin
                case (state_r)
                    HUNT: begin
                        state_s = HUNT;
                    end
                    CH1: begin
                        shift_s = word_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            hold_s    = word_s;
                            bit_cnt_s = {BW{1'b0}};
                            state_s   = CH2;
                        end else begin
                            bit_cnt_s = bit_cnt_r + BW'(1);
                        end
                    end
                    CH2: begin
                        shift_s = word_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            out1_s    = hold_r;
                            out2_s    = word_s;
                            valid_s   = 1'b1;
                            cnt_s     = cnt_r + CNT_W'(1);
                            bit_cnt_s = {BW{1'b0}};
                            state_s   = HUNT;
                        end else begin
                            bit_cnt_s = bit_cnt_r + BW'(1);
                        end
                    end
                    default: begin
                        bit_cnt_s = {BW{1'b0}};
                        state_s   = HUNT;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end

        select_s = (state_s == CH2);
    end

    // State and output registers; reset discards any partial frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= HUNT;
            shift_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            hold_r    <= {WIDTH{1'b0}};
            out1_r    <= {WIDTH{1'b0}};
            out2_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            select_r  <= 1'b0;
            ferr_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            hold_r    <= hold_s;
            out1_r    <= out1_s;
            out2_r    <= out2_s;
            valid_r   <= valid_s;
            select_r  <= select_s;
            ferr_r    <= ferr_s;
            cnt_r     <= cnt_s;
        end
    end

    assign out1      = out1_r;
    assign out2      = out2_r;
    assign valid     = valid_r;
    assign select    = select_r;
    assign frame_err = ferr_r;
    assign frame_cnt = cnt_r;

endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Directed bench for tdm_demux_1to2: frame-position reference, output scoreboard,
// and a second instance with a 2-bit frame counter to observe wrap-around.
module tb_tdm_demux_1to2;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] o1;
        logic [W-1:0] o2;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         sin = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] out1, out2, out1_b, out2_b;
    logic         valid, select, frame_err, valid_b, select_b, ferr_b;
    logic [7:0]   frame_cnt;
    logic [1:0]   cnt_b;

    int           checks = 0;
    int           errors = 0;
    pair_t        sb[$];
    int           cnt2_log[$];
    int           pos = -1;
    logic [2*W-1:0] fbits = '0;
    logic [W-1:0] hold_o1 = '0;
    logic [W-1:0] hold_o2 = '0;
    logic [7:0]   exp_cnt = 8'd0;
    int           exp_seq[5] = '{1, 2, 3, 0, 1};

    tdm_demux_1to2 #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sin(sin), .sync(sync),
        .out1(out1), .out2(out2), .valid(valid), .select(select),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    tdm_demux_1to2 #(.WIDTH(W), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .sin(sin), .sync(sync),
        .out1(out1_b), .out2(out2_b), .valid(valid_b), .select(select_b),
        .frame_err(ferr_b), .frame_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the frame-position reference, check outputs.
    task automatic tick(input logic e, input logic sy, input logic s);
        logic  ev, ef;
        pair_t p;
        en = e; sync = sy; sin = s;
        ev = 1'b0; ef = 1'b0;
        if (e) begin
            if (sy) begin
                ef    = (pos >= 0);
                pos   = 1;
                fbits = {{(2*W-1){1'b0}}, s};
            end else if (pos >= 0) begin
                fbits = {fbits[2*W-2:0], s};
                pos++;
                if (pos == 2*W) begin
                    ev   = 1'b1;
                    p.o1 = fbits[2*W-1:W];
                    p.o2 = fbits[W-1:0];
                    sb.push_back(p);
                    pos  = -1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("valid", valid, ev);
        chk("frame_err", frame_err, ef);
        chk("select", select, pos >= W);
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                p = sb.pop_front();
                chk("sb_out1", out1, p.o1);
                chk("sb_out2", out2, p.o2);
                hold_o1 = p.o1;
                hold_o2 = p.o2;
                exp_cnt = exp_cnt + 8'd1;
            end
            cnt2_log.push_back(int'(cnt_b));
        end
        chk("out1_hold", out1, hold_o1);
        chk("out2_hold", out2, hold_o2);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("frame_cnt_w2", cnt_b, exp_cnt[1:0]);
    endtask

    task automatic send_frame(input logic [2*W-1:0] bits);
        for (int i = 0; i < 2*W; i++) tick(1'b1, i == 0, bits[2*W-1-i]);
    endtask

    // Asserts reset between clock edges and checks outputs clear before any edge.
    task automatic async_reset();
        en = 1'b0;
        #3 rst = 1'b1;
        #1;
        pos = -1; hold_o1 = '0; hold_o2 = '0; exp_cnt = 8'd0; sb.delete();
        chk("rst_out1", out1, 0);
        chk("rst_out2", out2, 0);
        chk("rst_valid", valid, 0);
        chk("rst_select", select, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_frame_cnt_w2", cnt_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        async_reset();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);

        // basic frame
        send_frame(8'b1010_0110);
        tick(1'b0, 1'b0, 1'b0);
        chk("t1_out1", out1, 4'hA);
        chk("t1_out2", out2, 4'h6);
        chk("t1_cnt", frame_cnt, 8'd1);

        // same frame with EN gaps; SYNC held high in gaps must be ignored
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, i == 0, 8'b1010_0110 >> (7 - i));
            if (i == 2) repeat (3) tick(1'b0, 1'b1, 1'b1);
            if (i == 5) repeat (2) tick(1'b0, 1'b1, 1'b0);
        end
        chk("t2_out1", out1, 4'hA);
        chk("t2_out2", out2, 4'h6);

        // back-to-back frames
        send_frame(8'b1111_0000);
        send_frame(8'b0011_1100);
        chk("t3_out1", out1, 4'h3);
        chk("t3_out2", out2, 4'hC);

        // SYNC at bit 5 restarts the frame
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        send_frame(8'b0101_1001);
        chk("t4_out1", out1, 4'h5);
        chk("t4_out2", out2, 4'h9);

        chk("cnt2_log_len", cnt2_log.size(), 5);
        for (int i = 0; i < 5 && i < cnt2_log.size(); i++)
            chk("cnt2_seq", cnt2_log[i], exp_seq[i]);

        // reset mid-CH2, then unsynced bits, then a clean frame
        for (int i = 0; i < 7; i++) tick(1'b1, i == 0, 8'b1100_1010 >> (7 - i));
        async_reset();
        repeat (4) tick(1'b1, 1'b0, 1'b1);
        send_frame(8'b0111_1000);
        chk("t5_out1", out1, 4'h7);
        chk("t5_out2", out2, 4'h8);
        chk("t5_cnt", frame_cnt, 8'd1);
        tick(1'b0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
